// File: rtl/alk_pkg.sv
// alk_pkg: shared state, op and ALKCTL encodings for the alk_md_seq multiply/divide sequencer.
package alk_pkg;
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOOP, S_FIX, S_DONE} alk_state_e;
   typedef enum logic [1:0] {OP_MULP = 2'b00, OP_MULN = 2'b01, OP_DIVP = 2'b10, OP_DIVN = 2'b11} alk_op_e;
   localparam logic [9:0] ALK_249 = 10'h249;
   localparam logic [9:0] ALK_24B = 10'h24B;
   localparam logic [9:0] ALK_24C = 10'h24C;
   localparam logic [9:0] ALK_259 = 10'h259;
   localparam logic [9:0] ALK_25B = 10'h25B;
   localparam logic [9:0] ALK_25C = 10'h25C;
   localparam logic [9:0] ALK_26B = 10'h26B;
   function automatic logic op_is_div(alk_op_e op);
      return op == OP_DIVP || op == OP_DIVN;
   endfunction
endpackage

// File: rtl/alk_step_cnt.sv
// alk_step_cnt: falling-edge loop step counter with load, decrement and zero flag.
module alk_step_cnt #(
   parameter int CNT_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             dec_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             zero_o
);
   logic [CNT_W-1:0] cnt_q;
   always_ff @(negedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else if (load_i) cnt_q <= load_val_i;
      else if (dec_i) cnt_q <= cnt_q - CNT_W'(1);
   end
   assign cnt_o  = cnt_q;
   assign zero_o = cnt_q == '0;
endmodule

// File: rtl/alk_md_seq.sv
// alk_md_seq: multiply/divide ALKCTL sequencer, state on the falling edge of qdclk_l.
// Define ALK_MD_SEQ_REMFIX_EN to insert the FIX (remainder correction) state after DIV loops.
module alk_md_seq
   import alk_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             qdclk_l,
   input  logic             reset_h,
   input  logic             start_h,
   input  logic             abort_h,
   input  logic [1:0]       op_h,
   input  logic [9:0]       alpctl_h,
   input  logic             c32_in_h,
   input  logic             q_sout_shr_h,
   output logic [9:0]       alkctl_h,
   output logic             loop_flag_h,
   output logic             tog_flag_h,
   output logic             carry_invert_h,
   output logic             busy_h,
   output logic             done_h,
   output logic [CNT_W-1:0] step_cnt_h
);
`ifdef ALK_MD_SEQ_REMFIX_EN
   localparam bit REMFIX = 1'b1;
`else
   localparam bit REMFIX = 1'b0;
`endif
   alk_state_e state_q, state_d;
   alk_op_e    op_q, op_d;
   logic       tog_q, tog_d;
   logic       tog_src, cnt_zero, cnt_load, cnt_dec;
   assign tog_src = op_is_div(op_q) ? (c32_in_h ^ (op_q == OP_DIVN)) : q_sout_shr_h;
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         S_IDLE: if (start_h && !abort_h) begin
            state_d = S_SETUP;
            op_d    = alk_op_e'(op_h);
         end
         S_SETUP: state_d = abort_h ? S_IDLE : S_LOOP;
         S_LOOP: if (abort_h) state_d = S_IDLE;
            else if (cnt_zero) state_d = (REMFIX && op_is_div(op_q)) ? S_FIX : S_DONE;
         S_FIX: state_d = abort_h ? S_IDLE : S_DONE;
         default: state_d = S_IDLE;
      endcase
      // tog tracks the loop source only while looping or correcting; it reads 1 everywhere else
      tog_d = (state_d == S_LOOP || state_d == S_FIX) ? (state_q == S_LOOP ? tog_src : tog_q) : 1'b1;
   end
   always_ff @(negedge qdclk_l) begin
      if (reset_h) begin
         state_q <= S_IDLE;
         op_q    <= OP_MULP;
         tog_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         tog_q   <= tog_d;
      end
   end
   assign cnt_load = state_q == S_SETUP && !abort_h;
   assign cnt_dec  = state_q == S_LOOP && !cnt_zero && !abort_h;
   alk_step_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i     (qdclk_l),
      .rst_i     (reset_h),
      .load_i    (cnt_load),
      .dec_i     (cnt_dec),
      .load_val_i(CNT_W'(WIDTH - 1)),
      .cnt_o     (step_cnt_h),
      .zero_o    (cnt_zero)
   );
   always_comb begin
      alkctl_h = ALK_26B;
      case (state_q)
         S_IDLE:  alkctl_h = alpctl_h;
         S_SETUP: alkctl_h = !op_is_div(op_q) ? ALK_26B : (op_q == OP_DIVN) ? ALK_25C : ALK_24C;
         S_LOOP:  alkctl_h = op_is_div(op_q) ? (tog_q ? ALK_24C : ALK_25C) :
                             (op_q == OP_MULN) ? (tog_q ? ALK_249 : ALK_24B) : (tog_q ? ALK_259 : ALK_25B);
         S_FIX:   alkctl_h = tog_q ? ALK_26B : ALK_25C;
         default: alkctl_h = ALK_26B;
      endcase
   end
   assign carry_invert_h = state_q != S_IDLE && (alkctl_h == ALK_249 || alkctl_h == ALK_24C);
   assign loop_flag_h    = state_q == S_LOOP;
   assign busy_h         = state_q == S_SETUP || state_q == S_LOOP || state_q == S_FIX;
   assign done_h         = state_q == S_DONE;
   assign tog_flag_h     = tog_q;
endmodule

// File: tb/tb_alk_md_seq.sv
// tb_alk_md_seq: vector table of per-cycle inputs/expected outputs plus latency sequences, WIDTH=4.
module tb_alk_md_seq;
   localparam int WIDTH = 4;
   localparam int CNT_W = $clog2(WIDTH);
   logic             qdclk_l, reset_h, start_h, abort_h, c32_in_h, q_sout_shr_h;
   logic [1:0]       op_h;
   logic [9:0]       alpctl_h, alkctl_h;
   logic             loop_flag_h, tog_flag_h, carry_invert_h, busy_h, done_h;
   logic [CNT_W-1:0] step_cnt_h;
   alk_md_seq #(.WIDTH(WIDTH)) dut (
      .qdclk_l(qdclk_l), .reset_h(reset_h), .start_h(start_h), .abort_h(abort_h),
      .op_h(op_h), .alpctl_h(alpctl_h), .c32_in_h(c32_in_h), .q_sout_shr_h(q_sout_shr_h),
      .alkctl_h(alkctl_h), .loop_flag_h(loop_flag_h), .tog_flag_h(tog_flag_h),
      .carry_invert_h(carry_invert_h), .busy_h(busy_h), .done_h(done_h), .step_cnt_h(step_cnt_h)
   );
   typedef struct {
      logic       rst, st, ab;
      logic [1:0] op;
      logic [9:0] alp;
      logic       c32, qs;
      logic [9:0] alk;
      logic       tog, busy, done, lp, ci;
      int         cnt;
      logic       nc;
   } vec_t;
   vec_t vec[$];
   vec_t sb[$];
   int   lat_sb[$];
   int   errors = 0;
   int   checks = 0;
   initial qdclk_l = 1'b1;
   always #5 qdclk_l = ~qdclk_l;
   task automatic add(input logic r, s, a, input logic [1:0] op, input logic [9:0] alp, input logic c, q,
                      input logic [9:0] alk, input logic tog, busy, done, lp, ci, input int cnt, input logic nc);
      vec_t v;
      v.rst = r; v.st = s; v.ab = a; v.op = op; v.alp = alp; v.c32 = c; v.qs = q;
      v.alk = alk; v.tog = tog; v.busy = busy; v.done = done; v.lp = lp; v.ci = ci; v.cnt = cnt; v.nc = nc;
      vec.push_back(v);
   endtask
   task automatic chk(input string nm, input int row, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL row%0d %s actual=%0h required=%0h", row, nm, act, exp);
      end
   endtask
   task automatic run_lat(input logic [1:0] op, input int exp);
      int k;
      @(posedge qdclk_l);
      start_h = 1'b1; op_h = op; c32_in_h = 1'b0; q_sout_shr_h = 1'b0;
      lat_sb.push_back(exp);
      k = 0;
      do begin
         @(posedge qdclk_l);
         start_h = 1'b0;
         k++;
         #1;
      end while (!done_h && k < 40);
      chk($sformatf("latency op%0d", op), -1, k, lat_sb.pop_front());
      @(posedge qdclk_l);
      #1;
      chk($sformatf("done one-cycle op%0d", op), -1, int'(done_h), 0);
      repeat (2) @(posedge qdclk_l);
   endtask
   initial begin
      // MUL+ with q_sout 1,0,1,0 (first row checks reset state)
      add(0,0,0,0,'h155,0,0, 'h155,1,0,0,0,0,0,0);
      add(0,1,0,0,'h249,0,0, 'h249,1,0,0,0,0,0,0);
      add(0,0,0,3,'h000,0,0, 'h26B,1,1,0,0,0,0,0);
      add(0,0,0,3,'h000,0,1, 'h259,1,1,0,1,0,3,0);
      add(0,0,0,3,'h000,0,0, 'h259,1,1,0,1,0,2,0);
      add(0,0,0,3,'h000,0,1, 'h25B,0,1,0,1,0,1,0);
      add(0,0,0,3,'h000,0,0, 'h259,1,1,0,1,0,0,0);
      add(0,0,0,0,'h000,0,0, 'h26B,1,0,1,0,0,0,0);
      add(0,0,0,0,'h3AA,0,0, 'h3AA,1,0,0,0,0,0,0);
      // DIV- with c32 held low
      add(0,1,0,3,'h155,0,0, 'h155,1,0,0,0,0,0,0);
      add(0,0,0,0,'h000,0,0, 'h25C,1,1,0,0,0,0,0);
      for (int c = 3; c >= 0; c--) add(0,0,0,0,'h000,0,0, 'h24C,1,1,0,1,1,c,0);
`ifdef ALK_MD_SEQ_REMFIX_EN
      add(0,0,0,0,'h000,0,0, 'h26B,1,1,0,0,0,0,0);
`endif
      add(0,0,0,0,'h000,0,0, 'h26B,1,0,1,0,0,0,0);
      add(0,0,0,0,'h0F0,0,0, 'h0F0,1,0,0,0,0,0,0);
      // DIV+ with c32 1,0,1,0: last loop cycle leaves tog=0
      add(0,1,0,2,'h2AA,0,0, 'h2AA,1,0,0,0,0,0,0);
      add(0,0,0,0,'h000,0,0, 'h24C,1,1,0,0,1,0,0);
      add(0,0,0,0,'h000,1,0, 'h24C,1,1,0,1,1,3,0);
      add(0,0,0,0,'h000,0,0, 'h24C,1,1,0,1,1,2,0);
      add(0,0,0,0,'h000,1,0, 'h25C,0,1,0,1,0,1,0);
      add(0,0,0,0,'h000,0,0, 'h24C,1,1,0,1,1,0,0);
`ifdef ALK_MD_SEQ_REMFIX_EN
      add(0,0,0,0,'h000,0,0, 'h25C,0,1,0,0,0,0,0);
`endif
      add(0,0,0,0,'h000,0,0, 'h26B,1,0,1,0,0,0,0);
      add(0,0,0,0,'h1FF,0,0, 'h1FF,1,0,0,0,0,0,0);
      // MUL- aborted at step count 2
      add(0,1,0,1,'h155,0,0, 'h155,1,0,0,0,0,0,0);
      add(0,0,0,0,'h000,0,0, 'h26B,1,1,0,0,0,0,0);
      add(0,0,0,0,'h000,0,0, 'h249,1,1,0,1,1,3,0);
      add(0,0,1,0,'h000,0,0, 'h24B,0,1,0,1,0,2,0);
      add(0,0,0,0,'h0F0,0,0, 'h0F0,1,0,0,0,0,0,1);
      add(0,0,0,0,'h1FF,0,0, 'h1FF,1,0,0,0,0,0,1);
      // start held through a MUL+, then abort beats start in IDLE, then abort in SETUP
      add(0,1,0,0,'h155,0,1, 'h155,1,0,0,0,0,0,1);
      add(0,1,0,0,'h000,0,1, 'h26B,1,1,0,0,0,0,1);
      for (int c = 3; c >= 0; c--) add(0,1,0,0,'h000,0,1, 'h259,1,1,0,1,0,c,0);
      add(0,1,0,0,'h000,0,1, 'h26B,1,0,1,0,0,0,0);
      add(0,1,1,0,'h100,0,0, 'h100,1,0,0,0,0,0,0);
      add(0,1,0,0,'h101,0,0, 'h101,1,0,0,0,0,0,0);
      add(0,0,1,0,'h000,0,0, 'h26B,1,1,0,0,0,0,0);
      add(0,0,0,0,'h222,0,0, 'h222,1,0,0,0,0,0,1);
      // DIV- with c32 high, reset mid-loop, then a clean MUL+
      add(0,1,0,3,'h155,1,0, 'h155,1,0,0,0,0,0,1);
      add(0,0,0,0,'h000,1,0, 'h25C,1,1,0,0,0,0,1);
      add(0,0,0,0,'h000,1,0, 'h24C,1,1,0,1,1,3,0);
      add(1,0,0,0,'h000,1,0, 'h25C,0,1,0,1,0,2,0);
      add(0,1,0,0,'h3C3,0,1, 'h3C3,1,0,0,0,0,0,0);
      add(0,0,0,0,'h000,0,1, 'h26B,1,1,0,0,0,0,0);
      for (int c = 3; c >= 0; c--) add(0,0,0,0,'h000,0,1, 'h259,1,1,0,1,0,c,0);
      add(0,0,0,0,'h000,0,1, 'h26B,1,0,1,0,0,0,0);
      add(0,0,0,0,'h155,0,0, 'h155,1,0,0,0,0,0,0);
      reset_h = 1'b1; start_h = 1'b0; abort_h = 1'b0; op_h = 2'b00;
      alpctl_h = '0; c32_in_h = 1'b0; q_sout_shr_h = 1'b0;
      repeat (2) @(negedge qdclk_l);
      for (int i = 0; i < vec.size(); i++) begin
         vec_t e;
         @(posedge qdclk_l);
         reset_h = vec[i].rst; start_h = vec[i].st; abort_h = vec[i].ab; op_h = vec[i].op;
         alpctl_h = vec[i].alp; c32_in_h = vec[i].c32; q_sout_shr_h = vec[i].qs;
         sb.push_back(vec[i]);
         #1;
         e = sb.pop_front();
         chk("alkctl", i, int'(alkctl_h), int'(e.alk));
         chk("tog", i, int'(tog_flag_h), int'(e.tog));
         chk("busy", i, int'(busy_h), int'(e.busy));
         chk("done", i, int'(done_h), int'(e.done));
         chk("loop", i, int'(loop_flag_h), int'(e.lp));
         chk("carry_inv", i, int'(carry_invert_h), int'(e.ci));
         if (!e.nc) chk("step_cnt", i, int'(step_cnt_h), e.cnt);
      end
      @(posedge qdclk_l);
      start_h = 1'b0; abort_h = 1'b0; reset_h = 1'b0;
      run_lat(2'b00, WIDTH + 2);
`ifdef ALK_MD_SEQ_REMFIX_EN
      run_lat(2'b10, WIDTH + 3);
`else
      run_lat(2'b10, WIDTH + 2);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alk_md_seq.md
ALK_MD_SEQ -- requirements
Module: alk_md_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: loop iteration count, 4..64.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH): step counter width.
REQ-003 SHALL have these ports, one per line (name, direction, width, meaning):
- qdclk_l  in  1  clock; all state updates on the falling edge.
- reset_h  in  1  reset, synchronous, active-high.
- start_h  in  1  begin operation; sampled in IDLE only.
- abort_h  in  1  cancel operation.
- op_h  in  2  00 MUL+, 01 MUL-, 10 DIV+, 11 DIV-.
- alpctl_h  in  10  passthrough ALKCTL code used while IDLE.
- c32_in_h  in  1  ALU carry-out.
- q_sout_shr_h  in  1  Q-register shift-out.
- alkctl_h  out  10  ALKCTL opcode to the bitslices.
- loop_flag_h  out  1  high in LOOP.
- tog_flag_h  out  1  toggle flag.
- carry_invert_h  out  1  carry inversion.
- busy_h  out  1  high in SETUP, LOOP and FIX.
- done_h  out  1  one-cycle completion pulse.
- step_cnt_h  out  CNT_W  remaining iterations.
REQ-004 SHALL use one clock (qdclk_l); reset (reset_h) is synchronous and active-high.

Function
REQ-005 SHALL implement states IDLE, SETUP, LOOP, FIX, DONE.
REQ-006 SHALL transition as follows:
- IDLE->SETUP on start_h.
- SETUP->LOOP unconditionally.
- LOOP->LOOP while step_cnt_h != 0.
- LOOP->FIX at count 0 for DIV.
- LOOP->DONE at count 0 for MUL.
- FIX->DONE unconditionally.
- DONE->IDLE unconditionally.
REQ-007 SHALL latch op_h on the start edge and ignore op_h changes until IDLE.
REQ-008 SHALL load step_cnt_h with WIDTH-1 on entry to LOOP and decrement it once per LOOP cycle, giving exactly WIDTH LOOP cycles; the count holds outside LOOP.
REQ-009 SHALL preset tog_flag_h to 1 in IDLE, SETUP and DONE.
REQ-010 SHALL, in LOOP, load tog_flag_h from a source selected by the latched op:
- MUL: q_sout_shr_h.
- DIV+: c32_in_h.
- DIV-: ~c32_in_h.
REQ-011 SHALL drive alkctl_h combinationally per state (values hex):
- IDLE: alpctl_h.
- SETUP: MUL 26B; DIV+ 24C; DIV- 25C.
- LOOP, tog=1: MUL+ 259; MUL- 249; DIV 24C.
- LOOP, tog=0: MUL+ 25B; MUL- 24B; DIV 25C.
- FIX: 25C if tog=0, else 26B.
- DONE: 26B.
REQ-012 SHALL assert carry_invert_h iff state is not IDLE and alkctl_h equals 249 or 24C.
REQ-013 SHALL assert done_h only in DONE, for exactly one cycle.
REQ-014 SHALL ignore start_h outside IDLE.
REQ-015 SHALL, on abort_h in SETUP, LOOP or FIX, go to IDLE at the next edge; done_h is not asserted and tog is preset.
REQ-016 SHALL give abort_h priority over start_h when both are high in IDLE; state stays IDLE.
REQ-017 SHALL produce done_h WIDTH+3 edges after the start edge for DIV and WIDTH+2 for MUL, with FIX included.

Reset
REQ-018 SHALL, on reset_h at an edge, force:
- state IDLE;
- tog_flag_h 1;
- step_cnt_h 0;
- latched op 00;
- busy_h, done_h, loop_flag_h 0.
REQ-019 SHALL give reset_h priority over abort_h and start_h, and apply it mid-operation without a done_h pulse.

Configuration
REQ-020 SHALL use macro ALK_MD_SEQ_REMFIX_EN.
- Defined: the FIX state exists as specified.
- Undefined: DIV goes LOOP->DONE directly, FIX is never entered, and DIV latency is WIDTH+2.

Structure
REQ-021 SHALL place the following in a shared package alk_pkg:
- state enum;
- op_h encodings;
- ALKCTL constants 249, 24B, 24C, 259, 25B, 25C, 26B.
REQ-022 SHALL factor the step counter into a sub-module alk_step_cnt (load, decrement, zero flag), parametrised by CNT_W.

Verification
REQ-023 SHALL cover: WIDTH=4, MUL+, q_sout_shr_h=1,0,1,0 -> alkctl_h sequence 26B, 259, 259, 25B, 259, then 26B; done_h at edge 6.
REQ-024 SHALL cover: WIDTH=4, DIV-, c32_in_h=0 every cycle -> SETUP 25C, LOOP 24C then 24C thereafter; carry_invert_h high in LOOP; FIX 26B; done_h at edge 7.
REQ-025 SHALL cover: DIV+ with c32_in_h=0 in the last LOOP cycle -> FIX emits 25C; with the macro undefined, FIX is absent and done_h comes one edge earlier.
REQ-026 SHALL cover: abort_h asserted with step_cnt_h=2 -> IDLE next edge, busy_h=0, done_h never pulses, alkctl_h=alpctl_h.
REQ-027 SHALL cover: start_h held high through the whole op plus abort_h=1 with start_h in IDLE -> a second op only starts after DONE->IDLE; abort wins in IDLE.
REQ-028 SHALL cover: reset_h pulsed mid-LOOP -> all outputs at reset values next edge; a new start_h works normally.
